// File: rtl/emu_ctrl_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : emu_ctrl_clkgen
// Purpose  : Emulation control and clocking core. It converts host run/stall
//            control and the current emulation time into a stall time-step
//            request. It also generates the trace-decimation strobe, a
//            registered default-oscillator value with its rising-edge pulse,
//            and a divided debug-hub tick. All outputs are enables
//            synchronous to emu_clk.
// Revision : 1.0 - initial release
// ============================================================================
module emu_ctrl_clkgen #(
   parameter int DT_WIDTH   = 32,
   parameter int TIME_WIDTH = 64,
   parameter int DEC_WIDTH  = 24,
   parameter int DBG_DIV    = 4
) (
   input  logic                  emu_clk,
   input  logic                  emu_rst_n,
   input  logic [1:0]            emu_ctrl_mode,
   input  logic [TIME_WIDTH-1:0] emu_ctrl_data,
   input  logic [TIME_WIDTH-1:0] emu_time,
   input  logic [DEC_WIDTH-1:0]  emu_dec_thr,
   input  logic                  clk_val_default_osc,
   output logic [DT_WIDTH-1:0]   dt_req_stall,
   output logic                  emu_dec_cmp,
   output logic                  clk_default_osc,
   output logic                  osc_rise,
   output logic                  dbg_hub_tick
);

   localparam logic [1:0] MODE_RUN      = 2'd0;
   localparam logic [1:0] MODE_STALL    = 2'd1;
   localparam logic [1:0] MODE_STALL_AT = 2'd2;
   localparam logic [1:0] MODE_RUN_FOR  = 2'd3;

   localparam logic [DT_WIDTH-1:0]   DT_MAX     = '1;
   // Saturation limit widened to time width for the comparison.
   localparam logic [TIME_WIDTH-1:0] DT_MAX_EXT = TIME_WIDTH'(DT_MAX);

   localparam int                    DBG_W    = $clog2(DBG_DIV);
   localparam logic [DBG_W-1:0]      DBG_LAST = DBG_W'(DBG_DIV - 1);
   localparam logic [DBG_W-1:0]      DBG_ONE  = DBG_W'(1);
   localparam logic [DEC_WIDTH-1:0]  DEC_ONE  = DEC_WIDTH'(1);

   logic [1:0]            prev_mode;
   logic [TIME_WIDTH-1:0] target;
   logic [DEC_WIDTH-1:0]  dec_cnt;
   logic [DBG_W-1:0]      dbg_cnt;

   logic                  entry;
   logic [TIME_WIDTH-1:0] entry_target;
   logic [TIME_WIDTH-1:0] goal;
   logic [TIME_WIDTH-1:0] diff;
   logic [DT_WIDTH-1:0]   dt_next;

   // Work out the time goal for this cycle and the saturated step to it.
   always_comb begin
      entry        = (emu_ctrl_mode == MODE_RUN_FOR) && (prev_mode != MODE_RUN_FOR);
      // Wraps modulo 2^TIME_WIDTH by construction.
      entry_target = emu_time + emu_ctrl_data;
      goal         = target;
      if (emu_ctrl_mode == MODE_STALL_AT) begin
         goal = emu_ctrl_data;
      end else if (entry) begin
         // The entry cycle must already use the new target, before it is latched.
         goal = entry_target;
      end
      diff    = goal - emu_time;
      dt_next = '0;
      case (emu_ctrl_mode)
         MODE_RUN:   dt_next = DT_MAX;
         MODE_STALL: dt_next = '0;
         default: begin
            if (emu_time >= goal) begin
               dt_next = '0;
            end else if (diff > DT_MAX_EXT) begin
               dt_next = DT_MAX;
            end else begin
               dt_next = diff[DT_WIDTH-1:0];
            end
         end
      endcase
   end

   // Register the mode history, the run-for target and the stall request.
   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         prev_mode    <= 2'd0;
         target       <= '0;
         dt_req_stall <= '0;
      end else begin
         prev_mode    <= emu_ctrl_mode;
         dt_req_stall <= dt_next;
         if (entry) begin
            target <= entry_target;
         end
      end
   end

   // Decimation counter; it pulses once the count reaches the threshold.
   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         dec_cnt     <= '0;
         emu_dec_cmp <= 1'b0;
      end else if (dec_cnt >= emu_dec_thr) begin
         dec_cnt     <= '0;
         emu_dec_cmp <= 1'b1;
      end else begin
         dec_cnt     <= dec_cnt + DEC_ONE;
         emu_dec_cmp <= 1'b0;
      end
   end

   // Register the oscillator value and flag its 0->1 transitions.
   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         clk_default_osc <= 1'b0;
         osc_rise        <= 1'b0;
      end else begin
         clk_default_osc <= clk_val_default_osc;
         osc_rise        <= clk_val_default_osc & ~clk_default_osc;
      end
   end

   // Debug-hub divider; it ticks on the cycle the counter wraps to zero.
   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         dbg_cnt      <= '0;
         dbg_hub_tick <= 1'b0;
      end else if (dbg_cnt == DBG_LAST) begin
         dbg_cnt      <= '0;
         dbg_hub_tick <= 1'b1;
      end else begin
         dbg_cnt      <= dbg_cnt + DBG_ONE;
         dbg_hub_tick <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_emu_ctrl_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_ctrl_clkgen
// Purpose  : Self-checking bench for emu_ctrl_clkgen. It uses a behavioural
//            model and a scoreboard queue of expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emu_ctrl_clkgen;

   logic        emu_clk = 1'b0;
   logic        emu_rst_n;
   logic [1:0]  emu_ctrl_mode;
   logic [63:0] emu_ctrl_data;
   logic [63:0] emu_time;
   logic [23:0] emu_dec_thr;
   logic        clk_val_default_osc;
   logic [31:0] dt_req_stall;
   logic        emu_dec_cmp;
   logic        clk_default_osc;
   logic        osc_rise;
   logic        dbg_hub_tick;

   emu_ctrl_clkgen #(
      .DT_WIDTH  (32),
      .TIME_WIDTH(64),
      .DEC_WIDTH (24),
      .DBG_DIV   (4)
   ) dut (
      .emu_clk            (emu_clk),
      .emu_rst_n          (emu_rst_n),
      .emu_ctrl_mode      (emu_ctrl_mode),
      .emu_ctrl_data      (emu_ctrl_data),
      .emu_time           (emu_time),
      .emu_dec_thr        (emu_dec_thr),
      .clk_val_default_osc(clk_val_default_osc),
      .dt_req_stall       (dt_req_stall),
      .emu_dec_cmp        (emu_dec_cmp),
      .clk_default_osc    (clk_default_osc),
      .osc_rise           (osc_rise),
      .dbg_hub_tick       (dbg_hub_tick)
   );

   // Free-running emulation clock.
   always #5 emu_clk = ~emu_clk;

   typedef struct {
      logic [31:0] dt;
      logic        dec;
      logic        osc;
      logic        rise;
      logic        tick;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [1:0]  m_prev;
   logic [63:0] m_target;
   int          m_cnt;
   int          m_dbg;
   logic        m_osc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sat_step(input logic [63:0] tgt, input logic [63:0] tm);
      logic [63:0] d;
      if (tm >= tgt) return 32'h0;
      d = tgt - tm;
      if (d > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
      return d[31:0];
   endfunction

   task automatic model_reset();
      m_prev   = 2'd0;
      m_target = 64'd0;
      m_cnt    = 0;
      m_dbg    = 0;
      m_osc    = 1'b0;
   endtask

   // Apply one cycle of stimulus, queue its expected outputs, then compare
   // them after the next rising edge.
   task automatic drive_cycle(input string tag, input logic [1:0] mode,
                              input logic [63:0] data, input logic [63:0] tm,
                              input logic [23:0] thr, input logic osc);
      exp_t e;
      exp_t g;
      logic [63:0] tgt;
      emu_ctrl_mode       = mode;
      emu_ctrl_data       = data;
      emu_time            = tm;
      emu_dec_thr         = thr;
      clk_val_default_osc = osc;
      case (mode)
         2'd0: e.dt = 32'hFFFF_FFFF;
         2'd1: e.dt = 32'h0;
         2'd2: e.dt = sat_step(data, tm);
         default: begin
            if (m_prev != 2'd3) begin
               m_target = tm + data;
            end
            tgt  = m_target;
            e.dt = sat_step(tgt, tm);
         end
      endcase
      m_prev = mode;
      if (m_cnt >= int'(thr)) begin
         e.dec = 1'b1;
         m_cnt = 0;
      end else begin
         e.dec = 1'b0;
         m_cnt++;
      end
      e.osc  = osc;
      e.rise = osc & ~m_osc;
      m_osc  = osc;
      e.tick = (m_dbg == 3);
      m_dbg  = (m_dbg + 1) % 4;
      exp_q.push_back(e);
      @(posedge emu_clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         g = exp_q.pop_front();
         check({tag, "_dt"},   {32'h0, dt_req_stall}, {32'h0, g.dt});
         check({tag, "_dec"},  {63'h0, emu_dec_cmp},     {63'h0, g.dec});
         check({tag, "_osc"},  {63'h0, clk_default_osc}, {63'h0, g.osc});
         check({tag, "_rise"}, {63'h0, osc_rise},        {63'h0, g.rise});
         check({tag, "_tick"}, {63'h0, dbg_hub_tick},    {63'h0, g.tick});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dt"},   {32'h0, dt_req_stall}, 64'd0);
      check({tag, "_dec"},  {63'h0, emu_dec_cmp},     64'd0);
      check({tag, "_osc"},  {63'h0, clk_default_osc}, 64'd0);
      check({tag, "_rise"}, {63'h0, osc_rise},        64'd0);
      check({tag, "_tick"}, {63'h0, dbg_hub_tick},    64'd0);
   endtask

   // Assert reset between clock edges, check outputs without a clock edge,
   // then release reset on a falling edge.
   task automatic async_reset(input string tag);
      #3;
      emu_rst_n = 1'b0;
      #1;
      check_all_zero(tag);
      model_reset();
      exp_q.delete();
      @(negedge emu_clk);
      emu_rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] rm;
      emu_rst_n           = 1'b1;
      emu_ctrl_mode       = 2'd0;
      emu_ctrl_data       = 64'd0;
      emu_time            = 64'd0;
      emu_dec_thr         = 24'd3;
      clk_val_default_osc = 1'b0;
      model_reset();
      #2;
      emu_rst_n = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge emu_clk);
      emu_rst_n = 1'b1;

      // Run, then stall.
      drive_cycle("m0", 2'd0, 64'd0, 64'd0, 24'd3, 1'b0);
      check("m0_dtmax", {32'h0, dt_req_stall}, 64'hFFFF_FFFF);
      drive_cycle("m1", 2'd1, 64'd0, 64'd0, 24'd3, 1'b0);
      check("m1_zero", {32'h0, dt_req_stall}, 64'd0);

      // Stall at absolute time.
      drive_cycle("m2_t0",    2'd2, 64'd1000, 64'd0,    24'd3, 1'b0);
      check("m2_t0_abs", {32'h0, dt_req_stall}, 64'd1000);
      drive_cycle("m2_t400",  2'd2, 64'd1000, 64'd400,  24'd3, 1'b0);
      check("m2_t400_abs", {32'h0, dt_req_stall}, 64'd600);
      drive_cycle("m2_t999",  2'd2, 64'd1000, 64'd999,  24'd3, 1'b0);
      check("m2_t999_abs", {32'h0, dt_req_stall}, 64'd1);
      drive_cycle("m2_t1000", 2'd2, 64'd1000, 64'd1000, 24'd3, 1'b0);
      drive_cycle("m2_t1500", 2'd2, 64'd1000, 64'd1500, 24'd3, 1'b0);
      drive_cycle("m2_sat",   2'd2, 64'h100_0000_0000, 64'd0, 24'd3, 1'b0);
      check("m2_sat_abs", {32'h0, dt_req_stall}, 64'hFFFF_FFFF);

      // Run for interval: latch on entry, ignore data changes, re-latch.
      drive_cycle("m3_entry", 2'd3, 64'd50,  64'd200, 24'd3, 1'b0);
      check("m3_entry_abs", {32'h0, dt_req_stall}, 64'd50);
      drive_cycle("m3_hold",  2'd3, 64'd999, 64'd230, 24'd3, 1'b0);
      check("m3_hold_abs", {32'h0, dt_req_stall}, 64'd20);
      drive_cycle("m3_leave", 2'd0, 64'd999, 64'd230, 24'd3, 1'b0);
      drive_cycle("m3_reent", 2'd3, 64'd999, 64'd300, 24'd3, 1'b0);
      check("m3_reent_abs", {32'h0, dt_req_stall}, 64'd999);
      drive_cycle("m3_t1000", 2'd3, 64'd5,   64'd1000, 24'd3, 1'b0);
      check("m3_t1000_abs", {32'h0, dt_req_stall}, 64'd299);
      drive_cycle("m3_wrap",  2'd1, 64'd0,   64'd0,    24'd3, 1'b0);
      drive_cycle("m3_wrap2", 2'd3, 64'd10,  64'hFFFF_FFFF_FFFF_FFFC, 24'd3, 1'b0);

      // Decimation with thr=3, then thr=0, then lowering thr below the count.
      for (int i = 0; i < 12; i++) drive_cycle("dec3", 2'd0, 64'd0, 64'd0, 24'd3, 1'b0);
      for (int i = 0; i < 4; i++)  drive_cycle("dec0", 2'd0, 64'd0, 64'd0, 24'd0, 1'b0);
      for (int i = 0; i < 7; i++)  drive_cycle("dec10", 2'd0, 64'd0, 64'd0, 24'd10, 1'b0);
      drive_cycle("dec_lower", 2'd0, 64'd0, 64'd0, 24'd2, 1'b0);
      check("dec_lower_abs", {63'h0, emu_dec_cmp}, 64'd1);

      // Oscillator pattern 0,1,1,0,1.
      drive_cycle("osc0", 2'd0, 64'd0, 64'd0, 24'd5, 1'b0);
      drive_cycle("osc1", 2'd0, 64'd0, 64'd0, 24'd5, 1'b1);
      drive_cycle("osc2", 2'd0, 64'd0, 64'd0, 24'd5, 1'b1);
      drive_cycle("osc3", 2'd0, 64'd0, 64'd0, 24'd5, 1'b0);
      drive_cycle("osc4", 2'd0, 64'd0, 64'd0, 24'd5, 1'b1);

      // Reset in the middle of mode 3 and a decimation count.
      drive_cycle("pre_rst", 2'd3, 64'd100, 64'd500, 24'd6, 1'b1);
      drive_cycle("pre_rst", 2'd3, 64'd100, 64'd520, 24'd6, 1'b1);
      async_reset("midrst");
      drive_cycle("post_rst", 2'd3, 64'd5, 64'd600, 24'd2, 1'b0);
      check("post_rst_relatch", {32'h0, dt_req_stall}, 64'd5);
      for (int i = 0; i < 5; i++) drive_cycle("post_rst", 2'd3, 64'd77, 64'd601, 24'd2, 1'b0);

      // Mixed random traffic.
      for (int i = 0; i < 40; i++) begin
         rm = 2'($urandom_range(0, 3));
         drive_cycle("rnd", rm, 64'($urandom_range(0, 3000)), 64'($urandom_range(0, 3000)),
                     24'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
